// File: rtl/memory_test_master.sv
// Avalon-MM test master for a 64-bit x 1024-word memory: FILL writes seed+i over a
// wrapping word range, VERIFY reads it back and reports mismatches and an XOR checksum.
module memory_test_master #(
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        cmd_start,
    input  logic        cmd_op,
    input  logic [9:0]  cmd_base,
    input  logic [10:0] cmd_len,
    input  logic [63:0] cmd_seed,
    output logic        cmd_ready,
    output logic        done,
    output logic [10:0] err_count,
    output logic [9:0]  first_err_addr,
    output logic [63:0] checksum,

    output logic [9:0]  avm_address,
    output logic [7:0]  avm_byteenable,
    output logic        avm_chipselect,
    output logic        avm_write,
    output logic [63:0] avm_writedata,
    output logic        avm_read,
    input  logic [63:0] avm_readdata,
    input  logic        avm_waitrequest
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StDrain,
        StDone
    } state_e;

    state_e                  state_q;
    logic [9:0]              base_q;
    logic [10:0]             len_q;
    logic [63:0]             seed_q;
    logic [10:0]             req_idx_q;
    logic [10:0]             rsp_idx_q;
    logic [READ_LATENCY-1:0] rsp_valid_q;

    logic        req_accept;
    logic        req_last;
    logic [10:0] req_idx_nxt;
    logic [9:0]  req_addr_nxt;
    logic [63:0] req_data_nxt;
    logic        rsp_valid;
    logic        rsp_last;
    logic [63:0] rsp_expect;
    logic        rsp_mismatch;

    // A request is consumed by the slave only in a cycle without waitrequest.
    assign req_accept   = (avm_write | avm_read) & ~avm_waitrequest;
    assign req_last     = (req_idx_q == len_q - 11'd1);
    assign req_idx_nxt  = req_idx_q + 11'd1;
    assign req_addr_nxt = base_q + req_idx_nxt[9:0];
    assign req_data_nxt = seed_q + {53'd0, req_idx_nxt};

    // Returning read data lines up with the oldest stage of the valid pipeline.
    assign rsp_valid    = rsp_valid_q[READ_LATENCY-1];
    assign rsp_last     = (rsp_idx_q == len_q - 11'd1);
    assign rsp_expect   = seed_q + {53'd0, rsp_idx_q};
    assign rsp_mismatch = (avm_readdata != rsp_expect);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            base_q         <= '0;
            len_q          <= '0;
            seed_q         <= '0;
            req_idx_q      <= '0;
            rsp_idx_q      <= '0;
            rsp_valid_q    <= '0;
            cmd_ready      <= 1'b1;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            checksum       <= '0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_chipselect <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            avm_read       <= 1'b0;
        end else begin
            done <= 1'b0;

            for (int k = READ_LATENCY - 1; k > 0; k--) begin
                rsp_valid_q[k] <= rsp_valid_q[k-1];
            end
            rsp_valid_q[0] <= (state_q == StRead) & avm_read & ~avm_waitrequest;

            if (rsp_valid) begin
                checksum  <= checksum ^ avm_readdata;
                rsp_idx_q <= rsp_idx_q + 11'd1;
                if (rsp_mismatch) begin
                    err_count <= err_count + 11'd1;
                    if (err_count == 11'd0) begin
                        first_err_addr <= base_q + rsp_idx_q[9:0];
                    end
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (cmd_start) begin
                        base_q         <= cmd_base;
                        len_q          <= cmd_len;
                        seed_q         <= cmd_seed;
                        req_idx_q      <= '0;
                        rsp_idx_q      <= '0;
                        err_count      <= '0;
                        first_err_addr <= '0;
                        checksum       <= '0;
                        cmd_ready      <= 1'b0;
                        if (cmd_len == 11'd0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q        <= cmd_op ? StRead : StWrite;
                            avm_address    <= cmd_base;
                            avm_writedata  <= cmd_seed;
                            avm_byteenable <= 8'hFF;
                            avm_chipselect <= 1'b1;
                            avm_write      <= ~cmd_op;
                            avm_read       <= cmd_op;
                        end
                    end
                end

                StWrite: begin
                    if (req_accept) begin
                        if (req_last) begin
                            avm_write      <= 1'b0;
                            avm_chipselect <= 1'b0;
                            avm_byteenable <= '0;
                            state_q        <= StDone;
                            done           <= 1'b1;
                        end else begin
                            req_idx_q     <= req_idx_nxt;
                            avm_address   <= req_addr_nxt;
                            avm_writedata <= req_data_nxt;
                        end
                    end
                end

                StRead: begin
                    if (req_accept) begin
                        if (req_last) begin
                            avm_read       <= 1'b0;
                            avm_chipselect <= 1'b0;
                            avm_byteenable <= '0;
                            state_q        <= StDrain;
                        end else begin
                            req_idx_q   <= req_idx_nxt;
                            avm_address <= req_addr_nxt;
                        end
                    end
                end

                StDrain: begin
                    // The final response is checked this cycle; status is complete next cycle.
                    if (rsp_valid && rsp_last) begin
                        state_q <= StDone;
                        done    <= 1'b1;
                    end
                end

                StDone: begin
                    state_q   <= StIdle;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_test_master.sv
// Directed self-checking bench for memory_test_master with a behavioural
// latency-1 memory slave and tb-controlled waitrequest.
module tb_memory_test_master;

    localparam int unsigned LAT = 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_start;
    logic        cmd_op;
    logic [9:0]  cmd_base;
    logic [10:0] cmd_len;
    logic [63:0] cmd_seed;
    logic        cmd_ready;
    logic        done;
    logic [10:0] err_count;
    logic [9:0]  first_err_addr;
    logic [63:0] checksum;
    logic [9:0]  avm_address;
    logic [7:0]  avm_byteenable;
    logic        avm_chipselect;
    logic        avm_write;
    logic [63:0] avm_writedata;
    logic        avm_read;
    logic [63:0] avm_readdata;
    logic        avm_waitrequest;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    memory_test_master #(.READ_LATENCY(LAT)) dut (
        .clk             (clk),
        .reset           (reset),
        .cmd_start       (cmd_start),
        .cmd_op          (cmd_op),
        .cmd_base        (cmd_base),
        .cmd_len         (cmd_len),
        .cmd_seed        (cmd_seed),
        .cmd_ready       (cmd_ready),
        .done            (done),
        .err_count       (err_count),
        .first_err_addr  (first_err_addr),
        .checksum        (checksum),
        .avm_address     (avm_address),
        .avm_byteenable  (avm_byteenable),
        .avm_chipselect  (avm_chipselect),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_waitrequest (avm_waitrequest)
    );

    // Memory slave model plus a backdoor write port.
    logic [63:0] mem [1024];
    logic        corrupt_en;
    logic [9:0]  corrupt_addr;
    logic [63:0] corrupt_val;

    always @(posedge clk) begin
        if (avm_chipselect && avm_write && !avm_waitrequest) mem[avm_address] <= avm_writedata;
        if (avm_chipselect && avm_read && !avm_waitrequest) avm_readdata <= mem[avm_address];
        if (corrupt_en) mem[corrupt_addr] <= corrupt_val;
    end

    // Returns at the negedge of the cycle right after the accepting edge.
    task automatic start_cmd(input logic op, input logic [9:0] base, input logic [10:0] len,
                             input logic [63:0] seed);
        @(negedge clk);
        cmd_op    = op;
        cmd_base  = base;
        cmd_len   = len;
        cmd_seed  = seed;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic test_reset();
        logic [84:0] got;
        @(negedge clk);
        @(negedge clk);
        got = {avm_chipselect, avm_write, avm_read, avm_byteenable, avm_address, avm_writedata};
        total++;
        if (got !== 85'd0) $display("FAIL reset_avm got %h want 0", got);
        else passed++;
        total++;
        if ({cmd_ready, done, err_count, first_err_addr, checksum} !== {1'b1, 1'b0, 85'd0})
            $display("FAIL reset_status got %b %b %h %h %h want 1 0 0 0 0",
                     cmd_ready, done, err_count, first_err_addr, checksum);
        else passed++;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", cmd_ready);
        else passed++;
    endtask

    task automatic test_fill();
        logic [84:0] got, exp;
        start_cmd(1'b0, 10'd0, 11'd4, 64'h10);
        for (int i = 0; i < 4; i++) begin
            got = {avm_chipselect, avm_write, avm_read, avm_byteenable, avm_address, avm_writedata};
            exp = {3'b110, 8'hFF, 10'(i), 64'h10 + 64'(i)};
            total++;
            if (got !== exp || done !== 1'b0)
                $display("FAIL fill_beat%0d got %h done %b want %h done 0", i, got, done, exp);
            else passed++;
            @(negedge clk);
        end
        total++;
        if ({done, cmd_ready, avm_chipselect, avm_write, avm_byteenable} !== {4'b1000, 8'h00})
            $display("FAIL fill_done got done %b ready %b cs %b wr %b be %h want 1 0 0 0 00",
                     done, cmd_ready, avm_chipselect, avm_write, avm_byteenable);
        else passed++;
        @(negedge clk);
        total++;
        if ({done, cmd_ready} !== 2'b01)
            $display("FAIL fill_ready got done %b ready %b want 0 1", done, cmd_ready);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (mem[i] !== 64'h10 + 64'(i))
                $display("FAIL fill_mem%0d got %h want %h", i, mem[i], 64'h10 + 64'(i));
            else passed++;
        end
    endtask

    task automatic test_verify();
        logic [20:0] got, exp;
        start_cmd(1'b1, 10'd0, 11'd4, 64'h10);
        for (int i = 0; i < 4; i++) begin
            got = {avm_chipselect, avm_write, avm_read, avm_byteenable, avm_address};
            exp = {3'b101, 8'hFF, 10'(i)};
            total++;
            if (got !== exp) $display("FAIL verify_beat%0d got %h want %h", i, got, exp);
            else passed++;
            @(negedge clk);
        end
        total++;
        if ({done, avm_read, avm_chipselect} !== 3'b000)
            $display("FAIL verify_drain got done %b rd %b cs %b want 0 0 0",
                     done, avm_read, avm_chipselect);
        else passed++;
        @(negedge clk);
        total++;
        if ({done, err_count, first_err_addr, checksum} !== {1'b1, 85'd0})
            $display("FAIL verify_done got done %b err %0d first %0d sum %h want 1 0 0 0",
                     done, err_count, first_err_addr, checksum);
        else passed++;
    endtask

    task automatic test_corrupt();
        int k;
        @(negedge clk);
        corrupt_addr = 10'd2;
        corrupt_val  = 64'hDEAD;
        corrupt_en   = 1'b1;
        @(negedge clk);
        corrupt_en = 1'b0;
        start_cmd(1'b1, 10'd0, 11'd4, 64'h10);
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k != 6) $display("FAIL corrupt_latency got %0d want 6", k);
        else passed++;
        total++;
        if ({err_count, first_err_addr, checksum} !== {11'd1, 10'd2, 64'hDEBF})
            $display("FAIL corrupt_status got err %0d first %0d sum %h want 1 2 deb f",
                     err_count, first_err_addr, checksum);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_stall_fill();
        logic [84:0] got, exp;
        start_cmd(1'b0, 10'd1022, 11'd4, 64'h1FF);
        for (int k = 1; k <= 8; k++) begin
            avm_waitrequest = (k % 2 == 1);
            got = {avm_chipselect, avm_write, avm_read, avm_byteenable, avm_address, avm_writedata};
            exp = {3'b110, 8'hFF, 10'(1022 + (k - 1) / 2), 64'h1FF + 64'((k - 1) / 2)};
            total++;
            if (got !== exp || done !== 1'b0)
                $display("FAIL stall_fill_cyc%0d got %h done %b want %h done 0", k, got, done, exp);
            else passed++;
            @(negedge clk);
        end
        avm_waitrequest = 1'b0;
        total++;
        if ({done, avm_write} !== 2'b10)
            $display("FAIL stall_fill_done got done %b wr %b want 1 0", done, avm_write);
        else passed++;
        @(negedge clk);
        total++;
        if ({mem[1022], mem[1023], mem[0], mem[1]} !==
            {64'h1FF, 64'h200, 64'h201, 64'h202})
            $display("FAIL stall_fill_mem got %h %h %h %h want 1ff 200 201 202",
                     mem[1022], mem[1023], mem[0], mem[1]);
        else passed++;
    endtask

    task automatic test_stall_verify();
        int k;
        start_cmd(1'b1, 10'd1022, 11'd4, 64'h1FF);
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            avm_waitrequest = k[0];
            @(negedge clk);
            k++;
        end
        avm_waitrequest = 1'b0;
        total++;
        if (k != 10) $display("FAIL stall_verify_latency got %0d want 10", k);
        else passed++;
        total++;
        if ({err_count, first_err_addr, checksum} !== {11'd0, 10'd0, 64'h3FC})
            $display("FAIL stall_verify_status got err %0d first %0d sum %h want 0 0 3fc",
                     err_count, first_err_addr, checksum);
        else passed++;
        @(negedge clk);
    endtask

    task automatic test_len_zero();
        start_cmd(1'b1, 10'd5, 11'd0, 64'h0);
        total++;
        if ({done, avm_chipselect, avm_write, avm_read, avm_byteenable} !== {4'b1000, 8'h00})
            $display("FAIL len0_done got done %b cs %b wr %b rd %b be %h want 1 0 0 0 00",
                     done, avm_chipselect, avm_write, avm_read, avm_byteenable);
        else passed++;
        @(negedge clk);
        total++;
        if ({done, cmd_ready, avm_chipselect, avm_write, avm_read} !== 5'b01000)
            $display("FAIL len0_after got done %b ready %b cs %b wr %b rd %b want 0 1 0 0 0",
                     done, cmd_ready, avm_chipselect, avm_write, avm_read);
        else passed++;
    endtask

    task automatic test_busy_ignore();
        int ndone, first_k;
        ndone   = 0;
        first_k = 0;
        start_cmd(1'b0, 10'd100, 11'd4, 64'h77);
        for (int k = 1; k <= 12; k++) begin
            if (done === 1'b1) begin
                ndone++;
                if (first_k == 0) first_k = k;
            end
            if (k == 2) begin
                cmd_op    = 1'b0;
                cmd_base  = 10'd300;
                cmd_len   = 11'd0;
                cmd_start = 1'b1;
            end
            if (k == 4) cmd_start = 1'b0;
            @(negedge clk);
        end
        total++;
        if (ndone != 1 || first_k != 5)
            $display("FAIL busy_done got %0d pulses first at %0d want 1 at 5", ndone, first_k);
        else passed++;
        total++;
        if ({mem[100], mem[103]} !== {64'h77, 64'h7A})
            $display("FAIL busy_mem got %h %h want 77 7a", mem[100], mem[103]);
        else passed++;
    endtask

    task automatic test_reset_mid_read();
        int k;
        start_cmd(1'b1, 10'd0, 11'd8, 64'h999);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        total++;
        if ({cmd_ready, done, err_count, first_err_addr, checksum, avm_chipselect, avm_write,
             avm_read, avm_byteenable, avm_address, avm_writedata} !== {1'b1, 1'b0, 85'd0, 85'd0})
            $display("FAIL midreset_outputs got ready %b done %b err %0d sum %h cs %b rd %b",
                     cmd_ready, done, err_count, checksum, avm_chipselect, avm_read);
        else passed++;
        @(negedge clk);
        total++;
        if ({err_count, checksum, cmd_ready} !== {11'd0, 64'd0, 1'b1})
            $display("FAIL midreset_late_data got err %0d sum %h ready %b want 0 0 1",
                     err_count, checksum, cmd_ready);
        else passed++;
        start_cmd(1'b0, 10'd200, 11'd3, 64'h55);
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k != 4) $display("FAIL midreset_fill_latency got %0d want 4", k);
        else passed++;
        @(negedge clk);
        start_cmd(1'b1, 10'd200, 11'd3, 64'h55);
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (k != 5 || {err_count, first_err_addr, checksum} !== {11'd0, 10'd0, 64'h54})
            $display("FAIL midreset_verify got lat %0d err %0d first %0d sum %h want 5 0 0 54",
                     k, err_count, first_err_addr, checksum);
        else passed++;
    endtask

    initial begin
        reset           = 1'b1;
        cmd_start       = 1'b0;
        cmd_op          = 1'b0;
        cmd_base        = '0;
        cmd_len         = '0;
        cmd_seed        = '0;
        avm_waitrequest = 1'b0;
        corrupt_en      = 1'b0;
        corrupt_addr    = '0;
        corrupt_val     = '0;

        test_reset();
        test_fill();
        test_verify();
        test_corrupt();
        test_stall_fill();
        test_stall_verify();
        test_len_zero();
        test_busy_ignore();
        test_reset_mid_read();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
